// File: rtl/jtag_host_driver.sv
// rtl/jtag_host_driver.sv - host-side JTAG master turning reset/IR/DR/idle commands into TCK/TMS/TDI and capturing TDO
module jtag_host_driver #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_op,
    input  logic [LEN_W-1:0]   i_cmd_len,
    input  logic [MAX_LEN-1:0] i_cmd_data,
    output logic               o_rsp_valid,
    output logic [MAX_LEN-1:0] o_rsp_data,
    output logic               o_tck,
    output logic               o_tms,
    output logic               o_tdi,
    input  logic               i_tdo
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_SHIFT, S_TRAILER, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_idx, w_idx_nxt, r_len, w_len, w_len_in, w_hdr_last;
    logic [1:0]         r_op, w_op;
    logic [MAX_LEN-1:0] r_data, w_data, w_data_sh, r_cap, r_rsp_data;
    logic [DIV_W-1:0]   r_div;
    logic               r_tck, r_tms, r_tdi, w_tms_nxt, w_tdi_nxt;
    logic               w_accept, w_tick, w_rise, w_fall, w_busy;

    assign o_cmd_ready = (r_state == S_IDLE) && !i_rst;
    assign o_rsp_valid = (r_state == S_DONE);
    assign o_rsp_data  = r_rsp_data;
    assign o_tck       = r_tck;
    assign o_tms       = r_tms;
    assign o_tdi       = r_tdi;

    assign w_accept = i_cmd_valid && o_cmd_ready;
    assign w_busy   = (r_state == S_HEADER) || (r_state == S_SHIFT) || (r_state == S_TRAILER);
    assign w_tick   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_rise   = w_tick && !r_tck;
    assign w_fall   = w_tick && r_tck;

    // Zero-length scans still shift one bit; oversize requests are clamped.
    assign w_len_in = (i_cmd_len == '0) ? LEN_W'(1) :
                      (i_cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_cmd_len;

    assign w_op   = w_accept ? i_cmd_op   : r_op;
    assign w_len  = w_accept ? w_len_in   : r_len;
    assign w_data = w_accept ? i_cmd_data : r_data;

    assign w_hdr_last = (r_op == OP_RESET) ? LEN_W'(5) :
                        (r_op == OP_IR)    ? LEN_W'(3) : LEN_W'(2);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_idx_nxt   = '0;
                w_state_nxt = (i_cmd_op == OP_IDLE) ? S_SHIFT : S_HEADER;
            end
            S_HEADER: if (w_fall) begin
                if (r_idx == w_hdr_last) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = (r_op == OP_RESET) ? S_DONE : S_SHIFT;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_SHIFT: if (w_fall) begin
                if (r_idx == r_len - 1'b1) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = (r_op == OP_IDLE) ? S_DONE : S_TRAILER;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_TRAILER: if (w_fall) begin
                if (r_idx == LEN_W'(1)) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // TMS/TDI for the bit that begins at the next clk, so they change together with the falling TCK.
    assign w_data_sh = w_data >> w_idx_nxt;

    always_comb begin
        w_tms_nxt = 1'b0;
        w_tdi_nxt = 1'b0;
        case (w_state_nxt)
            S_HEADER: begin
                if (w_op == OP_RESET)   w_tms_nxt = (w_idx_nxt < LEN_W'(5));
                else if (w_op == OP_IR) w_tms_nxt = (w_idx_nxt < LEN_W'(2));
                else                    w_tms_nxt = (w_idx_nxt == '0);
            end
            S_SHIFT: if (w_op != OP_IDLE) begin
                w_tms_nxt = (w_idx_nxt == w_len - 1'b1);
                w_tdi_nxt = w_data_sh[0];
            end
            S_TRAILER: w_tms_nxt = (w_idx_nxt == '0);
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_op       <= OP_RESET;
            r_len      <= LEN_W'(1);
            r_data     <= '0;
            r_cap      <= '0;
            r_rsp_data <= '0;
            r_div      <= '0;
            r_tck      <= 1'b0;
            r_tms      <= 1'b1;
            r_tdi      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_accept) begin
                r_op   <= i_cmd_op;
                r_len  <= w_len_in;
                r_data <= i_cmd_data;
                r_cap  <= '0;
                r_div  <= '0;
                r_tck  <= 1'b0;
            end else if (w_busy) begin
                if (w_tick) begin
                    r_div <= '0;
                    r_tck <= ~r_tck;
                end else begin
                    r_div <= r_div + 1'b1;
                end
                if (w_rise && (r_state == S_SHIFT) && (r_op != OP_IDLE))
                    r_cap <= r_cap | (MAX_LEN'(i_tdo) << r_idx);
            end
            // TMS keeps its reset value of 1 until the first command is accepted.
            if ((r_state != S_IDLE) || w_accept) begin
                r_tms <= w_tms_nxt;
                r_tdi <= w_tdi_nxt;
            end
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE))
                r_rsp_data <= r_cap;
        end
    end
endmodule

// File: tb/tb_jtag_host_driver.sv
// tb/tb_jtag_host_driver.sv - bench driving jtag_host_driver into a TAP target model with randomized commands
module tb_jtag_host_driver;
    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [31:0]      cmd_data = '0;
    logic             rsp_valid;
    logic [31:0]      rsp_data;
    logic             tck, tms, tdi;
    logic             tdo = 1'b0;

    always #5 clk = ~clk;

    jtag_host_driver #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_len(cmd_len), .i_cmd_data(cmd_data),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_tck(tck), .o_tms(tms), .o_tdi(tdi), .i_tdo(tdo)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Target-side TAP with a 4-bit IR (0xF = BYPASS) and one shared 32-bit data register.
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t        tap = TLR;
    logic [3:0]  ir = 4'hF, ir_sr = 4'h0;
    logic [31:0] dr = 32'h0, dr_sr = 32'h0;
    logic        bp = 1'b0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            UPIR:  return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap)
            TLR:   ir <= 4'hF;
            CAPIR: ir_sr <= 4'b0001;
            SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
            UPIR:  ir <= ir_sr;
            CAPDR: if (ir == 4'hF) bp <= 1'b0; else dr_sr <= dr;
            SHDR:  if (ir == 4'hF) bp <= tdi; else dr_sr <= {tdi, dr_sr[31:1]};
            UPDR:  if (ir != 4'hF) dr <= dr_sr;
            default: ;
        endcase
        tap <= tap_next(tap, tms);
    end

    always @(negedge tck)
        tdo <= (tap == SHIR) ? ir_sr[0] : (tap == SHDR) ? ((ir == 4'hF) ? bp : dr_sr[0]) : 1'b0;

    // Pulse recorder: tms/tdi seen at each TCK rise, and high/low widths in clk cycles.
    int          np = 0, hi_run = 0, lo_run = 0, width_bad = 0;
    logic        prev_tck = 1'b0;
    logic [63:0] obs_tms = '0, obs_tdi = '0;

    always @(negedge clk) begin
        if (rst) begin
            hi_run = 0; lo_run = 0; prev_tck = 1'b0;
        end else begin
            if (tck && !prev_tck) begin
                if (np > 0 && lo_run != CLK_DIV) width_bad++;
                if (np < 64) begin
                    obs_tms[6'(np)] = tms;
                    obs_tdi[6'(np)] = tdi;
                end
                np++;
                hi_run = 1;
            end else if (tck) begin
                hi_run++;
            end else if (prev_tck) begin
                if (hi_run != CLK_DIV) width_bad++;
                lo_run = 1;
            end else begin
                lo_run++;
            end
            prev_tck = tck;
        end
    end

    logic [3:0]  exp_ir = 4'hF;
    logic [31:0] exp_dr = 32'h0;

    task automatic do_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                          input logic [31:0] data, input bit hold);
        int          L, n_exp, acc, busy_rdy;
        bit          got;
        logic [63:0] m, s, d, e_tms, e_tdi, e_rsp;
        L = (len == 0) ? 1 : (len > LEN_W'(MAX_LEN)) ? MAX_LEN : int'(len);
        m = (64'd1 << L) - 64'd1;
        d = {32'h0, data};
        e_tms = '0; e_tdi = '0; e_rsp = '0; n_exp = L;
        case (op)
            2'd0: begin n_exp = 6; e_tms = 64'h1F; exp_ir = 4'hF; end
            2'd1: begin
                n_exp = L + 6;
                e_tms = 64'h3 | (64'h3 << (L + 3));
                e_tdi = (d & m) << 4;
                s = (d << 4) | 64'h1;
                e_rsp = s & m;
                exp_ir = 4'(s >> L);
            end
            2'd2: begin
                n_exp = L + 5;
                e_tms = 64'h1 | (64'h3 << (L + 2));
                e_tdi = (d & m) << 3;
                if (exp_ir == 4'hF) s = d << 1;
                else begin
                    s = {32'h0, exp_dr} | (d << 32);
                    exp_dr = 32'(s >> L);
                end
                e_rsp = s & m;
            end
            default: ;
        endcase
        np = 0; acc = 0; busy_rdy = 0; got = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        for (int c = 0; c < 1000; c++) begin
            if (cmd_valid && cmd_ready) acc++;
            @(posedge clk); #1;
            if (acc > 0) begin
                if (!hold) cmd_valid = 1'b0;
                cmd_op = 2'($urandom); cmd_len = LEN_W'($urandom); cmd_data = $urandom;
            end
            if (rsp_valid) begin got = 1; cmd_valid = 1'b0; break; end
            if (acc > 0 && cmd_ready) busy_rdy++;
        end
        check_eq("rsp_seen", 64'(got), 64'd1);
        check_eq("accepts", 64'(acc), 64'd1);
        check_eq("ready_busy", 64'(busy_rdy), 64'd0);
        check_eq("tck_count", 64'(np), 64'(n_exp));
        check_eq("tms_seq", obs_tms & ((64'd1 << n_exp) - 64'd1), e_tms);
        check_eq("tdi_seq", obs_tdi & ((64'd1 << n_exp) - 64'd1), e_tdi);
        check_eq("rsp_data", 64'(rsp_data), e_rsp);
        check_eq("tap_rti", 64'(tap), 64'(RTI));
        check_eq("tap_ir", 64'(ir), 64'(exp_ir));
        check_eq("tap_dr", 64'(dr), 64'(exp_dr));
        @(posedge clk); #1;
        check_eq("post_done", 64'({rsp_valid, cmd_ready, tck, tms}), 64'b0100);
    endtask

    initial begin
        bit saw;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", 64'({cmd_ready, rsp_valid, tck, tms, tdi}), 64'b00010);
        check_eq("reset_rsp", 64'(rsp_data), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("ready_after_rst", 64'(cmd_ready), 64'd1);

        do_cmd(2'd0, 6'd0, 32'h0, 1'b0);
        do_cmd(2'd1, 6'd4, 32'h5, 1'b0);
        check_eq("ir_is_5", 64'(ir), 64'h5);
        do_cmd(2'd1, 6'd4, 32'hF, 1'b0);
        do_cmd(2'd2, 6'd8, 32'hA5, 1'b0);
        check_eq("bypass_a5", 64'(rsp_data), 64'h4A);
        do_cmd(2'd2, 6'd0, 32'hFFFF_FFFF, 1'b0);
        do_cmd(2'd2, 6'd40, 32'hDEAD_BEEF, 1'b1);
        do_cmd(2'd3, 6'd5, 32'hFFFF_FFFF, 1'b1);

        // Abort a DR scan while shift bit 3 is being clocked.
        np = 0;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 6'd8; cmd_data = 32'h3C;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 200 && np < 7; c++) begin @(posedge clk); #1; end
        check_eq("abort_reached", 64'(np), 64'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_outs", 64'({tck, tms, rsp_valid, cmd_ready}), 64'b0100);
        rst = 1'b0;
        saw = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) saw = 1;
        end
        check_eq("abort_no_rsp", 64'(saw), 64'd0);
        do_cmd(2'd0, 6'd3, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++)
            do_cmd(2'($urandom_range(0, 3)), LEN_W'($urandom_range(0, 40)),
                   $urandom, 1'($urandom_range(0, 1)));

        check_eq("tck_widths", 64'(width_bad), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
